// File: rtl/fetch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fetch_pkg : shared types and defaults for the MCU32X fetch front end        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package fetch_pkg;

  localparam int unsigned FETCH_XLEN      = 32;
  localparam int unsigned FETCH_ADDR_STEP = 4;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [FETCH_XLEN-1:0] instr;
  } fetch_entry_t;

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fetch_queue : synchronous prefetch FIFO; flush beats push and pop          |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module fetch_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic                       i_flush,
  input  logic [WIDTH-1:0]           i_wdata,
  output logic [WIDTH-1:0]           o_rdata,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_full,
  output logic                       o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_do_pop;
  logic             w_do_push;

  assign o_count   = r_count;
  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  // Head reads as zero while empty so stale storage never leaks out
  assign o_rdata   = o_empty ? '0 : r_mem[r_rptr];

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + AW'(1);
      if (w_do_pop)  r_rptr <= r_rptr + AW'(1);
      if (w_do_push && !w_do_pop)      r_count <= r_count + CW'(1);
      else if (!w_do_push && w_do_pop) r_count <= r_count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push && !i_flush) r_mem[r_wptr] <= i_wdata;
  end

endmodule : fetch_queue
`default_nettype wire

// File: rtl/fetch_pc_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fetch_pc_unit : PC generation, imem handshake and prefetch queue (MCU32X)  |
// | Optional macro FETCH_PERF_EN enables the perf_* counters. Rev 1.0          |
// +----------------------------------------------------------------------------+
module fetch_pc_unit
  import fetch_pkg::*;
#(
  parameter int unsigned     XLEN         = FETCH_XLEN,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int unsigned     ADDR_STEP    = FETCH_ADDR_STEP,
  parameter int unsigned     QUEUE_DEPTH  = 4
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  output logic            inst_valid,
  output logic [XLEN-1:0] inst_data,
  output logic [XLEN-1:0] inst_pc,
  input  logic            inst_ready,
  output logic [31:0]     perf_fetched,
  output logic [15:0]     perf_redirects
);

  localparam int unsigned CW = $clog2(QUEUE_DEPTH) + 1;
  localparam int unsigned EW = 2 * XLEN;

  fetch_state_t    r_state;
  fetch_state_t    w_state_nxt;
  logic [XLEN-1:0] r_fetch_pc;
  logic [XLEN-1:0] r_req_pc;
  logic            w_accept;
  logic            w_push;
  logic            w_pop;
  logic [EW-1:0]   w_head;
  logic [CW-1:0]   w_count;
  logic            w_full;
  logic            w_empty;

  assign imem_addr  = r_fetch_pc;
  assign w_accept   = imem_req && imem_ready;
  assign inst_valid = !w_empty;
  assign w_pop      = inst_valid && inst_ready;
  assign inst_pc    = w_head[EW-1:XLEN];
  assign inst_data  = w_head[XLEN-1:0];

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_REQ;
    else       r_state <= w_state_nxt;
  end

  // A redirect that coincides with acceptance or a pending request leaves one
  // response in flight, which S_DROP absorbs before fetching resumes.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_REQ: begin
        if (w_accept) w_state_nxt = redirect_valid ? S_DROP : S_WAIT;
      end
      S_WAIT: begin
        if (imem_rvalid)         w_state_nxt = S_REQ;
        else if (redirect_valid) w_state_nxt = S_DROP;
      end
      S_DROP: begin
        if (imem_rvalid) w_state_nxt = S_REQ;
      end
      default: w_state_nxt = S_REQ;
    endcase
  end

  always_comb begin
    imem_req = 1'b0;
    w_push   = 1'b0;
    case (r_state)
      S_REQ:   imem_req = (w_count < CW'(QUEUE_DEPTH)) && !reset;
      S_WAIT:  w_push   = imem_rvalid && !redirect_valid && !w_full;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_pc <= RESET_VECTOR;
      r_req_pc   <= '0;
    end else begin
      if (w_accept) r_req_pc <= r_fetch_pc;
      if (redirect_valid) r_fetch_pc <= redirect_target;
      else if (w_accept)  r_fetch_pc <= r_fetch_pc + XLEN'(ADDR_STEP);
    end
  end

  fetch_queue #(
    .DEPTH (QUEUE_DEPTH),
    .WIDTH (EW)
  ) u_queue (
    .clk     (clk),
    .rst     (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (redirect_valid),
    .i_wdata ({r_req_pc, imem_rdata}),
    .o_rdata (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

`ifdef FETCH_PERF_EN
  logic [31:0] r_perf_fetched;
  logic [15:0] r_perf_redirects;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf_fetched   <= '0;
      r_perf_redirects <= '0;
    end else begin
      if (w_push) r_perf_fetched <= r_perf_fetched + 32'd1;
      if (redirect_valid && (r_perf_redirects != 16'hFFFF))
        r_perf_redirects <= r_perf_redirects + 16'd1;
    end
  end

  assign perf_fetched   = r_perf_fetched;
  assign perf_redirects = r_perf_redirects;
`else
  assign perf_fetched   = '0;
  assign perf_redirects = '0;
`endif

endmodule : fetch_pc_unit
`default_nettype wire

// File: tb/tb_fetch_pc_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fetch_pc_unit : directed self-checking bench for fetch_pc_unit          |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_fetch_pc_unit;

  localparam logic [31:0] K = 32'h5A5A_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic [31:0] perf_fetched;
  logic [15:0] perf_redirects;

  int checks = 0;
  int errors = 0;

  logic        mem_hold = 1'b0;
  logic        m_acc;
  logic        m_rst;
  logic [31:0] m_addr;
  logic        m_pend;
  logic [31:0] m_paddr;

  fetch_pc_unit #(
    .XLEN         (32),
    .RESET_VECTOR (32'h0000_0000),
    .ADDR_STEP    (4),
    .QUEUE_DEPTH  (4)
  ) u_dut (
    .clk             (clk),
    .reset           (reset),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ready      (imem_ready),
    .imem_rvalid     (imem_rvalid),
    .imem_rdata      (imem_rdata),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .inst_valid      (inst_valid),
    .inst_data       (inst_data),
    .inst_pc         (inst_pc),
    .inst_ready      (inst_ready),
    .perf_fetched    (perf_fetched),
    .perf_redirects  (perf_redirects)
  );

  always #5 clk = ~clk;

  // Zero-wait memory: answers the cycle after acceptance unless held; reset squashes.
  initial begin
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    m_pend      = 1'b0;
    m_paddr     = '0;
    forever begin
      @(negedge clk);
      m_acc  = imem_req && imem_ready;
      m_addr = imem_addr;
      m_rst  = reset;
      @(posedge clk);
      #1;
      imem_rvalid = 1'b0;
      if (m_acc) begin
        m_pend  = 1'b1;
        m_paddr = m_addr;
      end
      if (m_rst) m_pend = 1'b0;
      if (m_pend && !mem_hold) begin
        imem_rvalid = 1'b1;
        imem_rdata  = m_paddr ^ K;
        m_pend      = 1'b0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // Leaves the bench 2ns into the first cycle after reset was sampled high.
  task automatic do_reset();
    reset          = 1'b1;
    redirect_valid = 1'b0;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    logic        ev;

    reset           = 1'b1;
    imem_ready      = 1'b1;
    inst_ready      = 1'b1;
    redirect_valid  = 1'b0;
    redirect_target = '0;

    // reset state
    cyc();
    cyc();
    @(negedge clk);
    chk("rst_req",   imem_req,       0);
    chk("rst_valid", inst_valid,     0);
    chk("rst_addr",  imem_addr,      32'h0);
    chk("rst_data",  inst_data,      0);
    chk("rst_pc",    inst_pc,        0);
    chk("rst_pf",    perf_fetched,   0);
    chk("rst_pr",    perf_redirects, 0);
    cyc();
    reset = 1'b0;

    // sequential fetch, one instruction per two cycles
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (c % 2 == 1) begin
        chk("seq_req",  imem_req,  1);
        chk("seq_addr", imem_addr, 32'(2 * (c - 1)));
      end else begin
        chk("seq_req",  imem_req,  0);
      end
      ev = (c >= 3) && (c % 2 == 1);
      chk("seq_valid", inst_valid, ev);
      if (ev) begin
        a = 32'(2 * (c - 3));
        chk("seq_pc",   inst_pc,   a);
        chk("seq_data", inst_data, a ^ K);
      end
      cyc();
    end

    // back-pressure fills the queue and stalls fetch
    inst_ready = 1'b0;
    do_reset();
    repeat (8) cyc();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("full_req",   imem_req,   0);
      chk("full_valid", inst_valid, 1);
      chk("full_pc",    inst_pc,    32'h0);
      cyc();
    end
    inst_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("drain_valid", inst_valid, 1);
      chk("drain_pc",    inst_pc,    32'(4 * k));
      chk("drain_data",  inst_data,  32'(4 * k) ^ K);
      cyc();
    end

    // redirect while waiting for a held response
    mem_hold = 1'b1;
    do_reset();
    cyc();
    redirect_valid  = 1'b1;
    redirect_target = 32'h100;
    cyc();
    redirect_valid = 1'b0;
    mem_hold       = 1'b0;
    for (int c = 3; c <= 7; c++) begin
      @(negedge clk);
      if (c == 7) begin
        chk("rdw_valid", inst_valid, 1);
        chk("rdw_pc",    inst_pc,    32'h100);
        chk("rdw_data",  inst_data,  32'h100 ^ K);
      end else begin
        chk("rdw_valid", inst_valid, 0);
        chk("rdw_req",   imem_req,   (c == 5) ? 1 : 0);
        if (c == 5) chk("rdw_addr", imem_addr, 32'h100);
      end
      cyc();
    end

    // redirect in the same cycle the request is accepted
    do_reset();
    redirect_valid  = 1'b1;
    redirect_target = 32'h200;
    cyc();
    redirect_valid = 1'b0;
    for (int c = 2; c <= 5; c++) begin
      @(negedge clk);
      if (c == 5) begin
        chk("rda_valid", inst_valid, 1);
        chk("rda_pc",    inst_pc,    32'h200);
      end else begin
        chk("rda_valid", inst_valid, 0);
        chk("rda_req",   imem_req,   (c == 3) ? 1 : 0);
        if (c == 3) chk("rda_addr", imem_addr, 32'h200);
      end
      cyc();
    end

    // address wrap near the top of the address space
    do_reset();
    redirect_valid  = 1'b1;
    redirect_target = 32'hFFFF_FFF8;
    imem_ready      = 1'b0;
    cyc();
    redirect_valid = 1'b0;
    imem_ready     = 1'b1;
    for (int c = 2; c <= 8; c++) begin
      @(negedge clk);
      if (c % 2 == 0) begin
        a = 32'hFFFF_FFF8 + 32'(2 * (c - 2));
        chk("wrap_req",  imem_req,  1);
        chk("wrap_addr", imem_addr, a);
        if (c >= 4) begin
          a = 32'hFFFF_FFF8 + 32'(2 * (c - 4));
          chk("wrap_valid", inst_valid, 1);
          chk("wrap_pc",    inst_pc,    a);
        end
      end
      if (c == 8) mem_hold = 1'b1;
      cyc();
    end

    // reset during an outstanding fetch
    reset = 1'b1;
    cyc();
    reset    = 1'b0;
    mem_hold = 1'b0;
    @(negedge clk);
    chk("rmid_req",   imem_req,   1);
    chk("rmid_addr",  imem_addr,  32'h0);
    chk("rmid_valid", inst_valid, 0);
    cyc();
    @(negedge clk);
    chk("rmid_valid2", inst_valid, 0);
    cyc();
    @(negedge clk);
    chk("rmid_valid3", inst_valid, 1);
    chk("rmid_pc",     inst_pc,    32'h0);

    // performance counters: 10 pushes then 3 redirects without fetching
    cyc();
    do_reset();
    repeat (20) cyc();
    imem_ready = 1'b0;
    for (int r = 0; r < 3; r++) begin
      redirect_valid  = 1'b1;
      redirect_target = 32'h300 + 32'(4 * r);
      cyc();
      redirect_valid = 1'b0;
      @(negedge clk);
      chk("perf_flush", inst_valid, 0);
      cyc();
    end
    @(negedge clk);
    chk("perf_addr", imem_addr, 32'h308);
`ifdef FETCH_PERF_EN
    chk("perf_fetched",   perf_fetched,   32'd10);
    chk("perf_redirects", perf_redirects, 32'd3);
`else
    chk("perf_fetched",   perf_fetched,   32'd0);
    chk("perf_redirects", perf_redirects, 32'd0);
`endif
    imem_ready = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_fetch_pc_unit
`default_nettype wire
